// File: rtl/recep_frame_tx.sv
// recep_frame_tx: serialises a temperature/alarm snapshot, or the receiver-clear
// sequence, as a scancode frame on DATO with one FLAG strobe per byte.
// Optional feature macro: RECEP_ALARM_ONLY_EN (adds ALARM_ONLY input for
// alarm-only frames that omit the temperature bytes).
module recep_frame_tx #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SEND_RESET,
    input  logic [7:0] TEMP1,
    input  logic [7:0] TEMP2,
    input  logic       PELIGRO,
    input  logic       ALERTA,
    input  logic       GAS,
`ifdef RECEP_ALARM_ONLY_EN
    input  logic       ALARM_ONLY,
`endif
    output logic [7:0] DATO,
    output logic       FLAG,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int unsigned MAX_BYTES = 5;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CNT_W     = 8;

    localparam logic [7:0] CODE_ENTER  = 8'h5A;
    localparam logic [7:0] CODE_RESET  = 8'h2D;
    localparam logic [7:0] CODE_P      = 8'h4D;
    localparam logic [7:0] CODE_A      = 8'h1C;
    localparam logic [7:0] CODE_G      = 8'h34;
    localparam logic [7:0] CODE_H      = 8'h33;
    localparam logic [7:0] CODE_FILLER = 8'h00;

    // SETUP/STROBE/GAP name the phase shown on the outputs in the current
    // cycle; NEXT is the one-cycle load phase between acceptance and byte 0.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_NEXT
    } state_t;

    state_t                         state;
    logic [MAX_BYTES-1:0][7:0]      frm_q;
    logic [IDX_W-1:0]               len_q;
    logic [IDX_W-1:0]               idx_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           rej_q;

    logic [MAX_BYTES-1:0][7:0]      frm_c;
    logic [IDX_W-1:0]               len_c;
    logic                           bad_c;
    logic                           alarm_c;
    logic [7:0]                     alarm_code_c;
    logic                           alarm_only_c;

    // Build the candidate byte list and rejection check from the live inputs.
    always_comb begin
        frm_c        = '0;
        len_c        = '0;
        bad_c        = 1'b0;
        alarm_c      = PELIGRO | ALERTA;
        alarm_code_c = PELIGRO ? CODE_P : CODE_A;
`ifdef RECEP_ALARM_ONLY_EN
        alarm_only_c = ALARM_ONLY;
`else
        alarm_only_c = 1'b0;
`endif
        if (SEND_RESET) begin
            frm_c[0] = CODE_RESET;
            frm_c[1] = CODE_FILLER;
            len_c    = IDX_W'(2);
        end else begin
            if (alarm_only_c) begin
                frm_c[len_c] = CODE_H;
                len_c        = len_c + IDX_W'(1);
            end else begin
                frm_c[0] = TEMP1;
                frm_c[1] = TEMP2;
                len_c    = IDX_W'(2);
                bad_c    = (TEMP1 == CODE_ENTER) || (TEMP1 == CODE_H) ||
                           (TEMP1 == CODE_RESET) || (TEMP2 == CODE_ENTER);
            end
            if (alarm_c) begin
                frm_c[len_c] = alarm_code_c;
                len_c        = len_c + IDX_W'(1);
            end
            if (alarm_c && GAS) begin
                frm_c[len_c] = CODE_G;
                len_c        = len_c + IDX_W'(1);
            end
            frm_c[len_c] = CODE_ENTER;
            len_c        = len_c + IDX_W'(1);
        end
    end

    // Sequencer: snapshot on acceptance, then SETUP/STROBE/GAP per byte.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            DATO  <= CODE_ENTER;
            FLAG  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            rej_q <= 1'b0;
            frm_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            DONE  <= 1'b0;
            ERR   <= rej_q;
            rej_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (SEND_RESET || (START && !bad_c)) begin
                        frm_q <= frm_c;
                        len_q <= len_c;
                        idx_q <= '0;
                        state <= S_NEXT;
                    end else if (START) begin
                        rej_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    DATO  <= frm_q[idx_q];
                    BUSY  <= 1'b1;
                    state <= S_SETUP;
                end
                S_SETUP: begin
                    FLAG  <= 1'b1;
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    FLAG  <= 1'b0;
                    cnt_q <= CNT_W'(GAP_CYCLES - 1);
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (idx_q == len_q - IDX_W'(1)) begin
                        DATO  <= CODE_ENTER;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        DATO  <= frm_q[idx_q + IDX_W'(1)];
                        state <= S_SETUP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recep_frame_tx.sv
// tb_recep_frame_tx: table-driven directed check of recep_frame_tx (GAP_CYCLES=2).
module tb_recep_frame_tx;

    localparam int unsigned GAP = 2;
    localparam int unsigned PER = 2 + GAP;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       SEND_RESET;
    logic [7:0] TEMP1;
    logic [7:0] TEMP2;
    logic       PELIGRO;
    logic       ALERTA;
    logic       GAS;
`ifdef RECEP_ALARM_ONLY_EN
    logic       ALARM_ONLY;
`endif
    logic [7:0] DATO;
    logic       FLAG;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    recep_frame_tx #(.GAP_CYCLES(GAP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .SEND_RESET(SEND_RESET),
        .TEMP1     (TEMP1),
        .TEMP2     (TEMP2),
        .PELIGRO   (PELIGRO),
        .ALERTA    (ALERTA),
        .GAS       (GAS),
`ifdef RECEP_ALARM_ONLY_EN
        .ALARM_ONLY(ALARM_ONLY),
`endif
        .DATO      (DATO),
        .FLAG      (FLAG),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic            st;
        logic            sr;
        logic [7:0]      t1;
        logic [7:0]      t2;
        logic            p;
        logic            a;
        logic            g;
        logic            poke;
        logic [2:0]      n;
        logic [4:0][7:0] b;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sr,
                                input logic [7:0] t1, input logic [7:0] t2,
                                input logic p, input logic a, input logic g,
                                input logic poke, input int n,
                                input logic [39:0] bytes);
        vec_t v;
        v.st = st; v.sr = sr; v.t1 = t1; v.t2 = t2;
        v.p = p; v.a = a; v.g = g; v.poke = poke;
        v.n = 3'(n);
        for (int i = 0; i < 5; i++) v.b[i] = bytes[39-8*i -: 8];
        return v;
    endfunction

    // Apply one request and observe the following 30 cycles (sample j = cycle k+j).
    task automatic run(input string tag, input vec_t v);
        int       nflag, ndone, nerr, busy_n, done_cyc, err_cyc;
        int       fcyc[5];
        logic [7:0] got[5];
        logic     prevf, dbl;
        logic [7:0] dato_done, dato_end;
        @(negedge CLK);
        START = v.st; SEND_RESET = v.sr;
        TEMP1 = v.t1; TEMP2 = v.t2;
        PELIGRO = v.p; ALERTA = v.a; GAS = v.g;
        @(posedge CLK);
        #1;
        START = 1'b0; SEND_RESET = 1'b0;
        TEMP1 = ~v.t1; TEMP2 = ~v.t2;
        PELIGRO = ~v.p; ALERTA = ~v.a; GAS = ~v.g;
        nflag = 0; ndone = 0; nerr = 0; busy_n = 0; done_cyc = -1; err_cyc = -1;
        prevf = 1'b0; dbl = 1'b0; dato_done = 8'h00; dato_end = 8'h00;
        for (int i = 0; i < 5; i++) begin fcyc[i] = -1; got[i] = 8'h00; end
        for (int j = 0; j < 30; j++) begin
            @(negedge CLK);
            if (FLAG) begin
                if (nflag < 5) begin got[nflag] = DATO; fcyc[nflag] = j; end
                nflag++;
                if (prevf) dbl = 1'b1;
            end
            prevf = FLAG;
            if (BUSY) busy_n++;
            if (DONE) begin ndone++; done_cyc = j; dato_done = DATO; end
            if (ERR) begin nerr++; err_cyc = j; end
            dato_end = DATO;
            START = v.poke && (j == 0 || j == 5);
        end
        START = 1'b0;
        chk({tag, " nbytes"}, nflag, int'(v.n));
        for (int i = 0; i < int'(v.n) && i < 5; i++) begin
            chk($sformatf("%s byte%0d", tag, i), int'(got[i]), int'(v.b[i]));
            chk($sformatf("%s flag_cyc%0d", tag, i), fcyc[i], 2 + int'(PER) * i);
        end
        chk({tag, " flag_double"}, int'(dbl), 0);
        chk({tag, " dato_end"}, int'(dato_end), 8'h5A);
        if (v.n != 0) begin
            chk({tag, " done_cnt"}, ndone, 1);
            chk({tag, " done_cyc"}, done_cyc, 1 + int'(PER) * int'(v.n));
            chk({tag, " dato_at_done"}, int'(dato_done), 8'h5A);
            chk({tag, " busy_cycles"}, busy_n, int'(PER) * int'(v.n));
            chk({tag, " err_cnt"}, nerr, 0);
        end else begin
            chk({tag, " err_cnt"}, nerr, 1);
            chk({tag, " err_cyc"}, err_cyc, 1);
            chk({tag, " busy_cycles"}, busy_n, 0);
            chk({tag, " done_cnt"}, ndone, 0);
        end
    endtask

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nf, bad_after;
        vecs[0]  = mk(1,0,8'h25,8'h16,1,0,1,0,5,{8'h25,8'h16,8'h4D,8'h34,8'h5A});
        vecs[1]  = mk(1,0,8'h30,8'h31,0,1,0,1,4,{8'h30,8'h31,8'h1C,8'h5A,8'h00});
        vecs[2]  = mk(1,0,8'h33,8'h10,1,0,0,0,0,40'h0);
        vecs[3]  = mk(1,0,8'h40,8'h5A,0,1,0,0,0,40'h0);
        vecs[4]  = mk(1,1,8'h33,8'h10,1,0,1,0,2,{8'h2D,8'h00,8'h00,8'h00,8'h00});
        vecs[5]  = mk(0,1,8'h11,8'h12,0,0,0,0,2,{8'h2D,8'h00,8'h00,8'h00,8'h00});
        vecs[6]  = mk(1,0,8'h20,8'h21,0,0,1,0,3,{8'h20,8'h21,8'h5A,8'h00,8'h00});
        vecs[7]  = mk(1,0,8'h41,8'h42,1,1,0,0,4,{8'h41,8'h42,8'h4D,8'h5A,8'h00});
        vecs[8]  = mk(1,0,8'h43,8'h44,0,1,1,1,5,{8'h43,8'h44,8'h1C,8'h34,8'h5A});
        vecs[9]  = mk(1,0,8'h5A,8'h10,0,0,0,0,0,40'h0);
        vecs[10] = mk(1,0,8'h2D,8'h10,0,1,0,0,0,40'h0);
        vecs[11] = mk(1,0,8'h12,8'h33,0,0,0,0,3,{8'h12,8'h33,8'h5A,8'h00,8'h00});

        RST = 1'b1; START = 1'b0; SEND_RESET = 1'b0;
        TEMP1 = 8'h00; TEMP2 = 8'h00; PELIGRO = 1'b0; ALERTA = 1'b0; GAS = 1'b0;
`ifdef RECEP_ALARM_ONLY_EN
        ALARM_ONLY = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset DATO", int'(DATO), 8'h5A);
        chk("reset FLAG", int'(FLAG), 0);
        chk("reset BUSY", int'(BUSY), 0);
        chk("reset DONE", int'(DONE), 0);
        chk("reset ERR", int'(ERR), 0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) run($sformatf("vec%0d", i), vecs[i]);

        // Reset during the third byte's gap abandons the frame.
        @(negedge CLK);
        START = 1'b1; TEMP1 = 8'h25; TEMP2 = 8'h16; PELIGRO = 1'b1; ALERTA = 1'b0; GAS = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        nf = 0;
        for (int j = 0; j <= 11; j++) begin
            @(negedge CLK);
            if (FLAG) nf++;
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid flags_before", nf, 3);
        chk("rst_mid DATO", int'(DATO), 8'h5A);
        chk("rst_mid FLAG", int'(FLAG), 0);
        chk("rst_mid BUSY", int'(BUSY), 0);
        chk("rst_mid DONE", int'(DONE), 0);
        RST = 1'b0;
        bad_after = 0;
        run("after_rst", vecs[0]);
        @(negedge CLK);
        if (DONE || FLAG || BUSY) bad_after++;
        chk("quiet_after", bad_after, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/recep_frame_tx.md
Name: recep_frame_tx

Overview:
- Transmit-side counterpart of the keyboard-code receiver that extracts temperature digits and alarm flags from a DATO/flag byte stream.
- Takes a snapshot of two temperature bytes and three alarm bits, then serialises them as a scancode frame on DATO, strobing FLAG once per byte.
- Drives the status panel from the sensor side, or acts as a bench/loopback source for the receiver.
- Also emits the receiver-clear sequence on request.

Parameters:
GAP_CYCLES, 4, idle cycles after each FLAG pulse before the next byte is driven (legal range 1..255).

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous reset, active-high.
START  in  1  one-cycle request to send a data frame.
SEND_RESET  in  1  one-cycle request to send the clear sequence.
TEMP1  in  8  first temperature code byte.
TEMP2  in  8  second temperature code byte.
PELIGRO  in  1  danger alarm.
ALERTA  in  1  smoke alert.
GAS  in  1  gas present.
DATO  out  8  byte presented to the receiver.
FLAG  out  1  byte strobe; the receiver samples DATO on its rising edge.
BUSY  out  1  high while a frame or clear sequence is in progress.
DONE  out  1  one-cycle pulse when a sequence completes.
ERR  out  1  one-cycle pulse when a START is rejected.

Behaviour:
- Codes: ENTER 8'h5A, RESET 8'h2D, P 8'h4D, A 8'h1C, G 8'h34, H 8'h33, FILLER 8'h00.
- Reset values:
  - DATO = 8'h5A. Idling on ENTER holds the receiver in its start state.
  - FLAG = 0, BUSY = 0, DONE = 0, ERR = 0.
- States: IDLE, SETUP, STROBE, GAP, NEXT.
- Per-byte timing:
  - SETUP: DATO takes the new byte; FLAG = 0 (1 cycle).
  - STROBE: FLAG = 1; DATO held (1 cycle).
  - GAP: FLAG = 0; DATO held (GAP_CYCLES cycles).
  - Byte period = 2 + GAP_CYCLES cycles.
- Acceptance: START or SEND_RESET sampled high in IDLE at edge k.
  - TEMP1, TEMP2, PELIGRO, ALERTA, GAS are snapshotted at edge k.
  - BUSY = 1 from k+1.
  - First byte on DATO at k+1; first FLAG at k+2.
- Data frame byte list, built from the snapshot:
  - TEMP1, then TEMP2.
  - If PELIGRO: P. Else if ALERTA: A.
  - If (PELIGRO or ALERTA) and GAS: G.
  - Always end with ENTER.
  - GAS with no alarm sends no G.
- Clear sequence: RESET, then FILLER. The second strobe performs the receiver clear. FILLER is used because ENTER would pre-empt the receiver's clear state.
- Completion:
  - After the last byte's GAP: DATO returns to 8'h5A, BUSY = 0, and DONE = 1 for one cycle, all in the same cycle.
  - Return to IDLE. A new request is accepted in the cycle following DONE.
- Rejection: START is rejected when TEMP1 ∈ {5A, 33, 2D} or TEMP2 == 5A, since the receiver would misparse these.
  - On rejection: ERR pulses one cycle (at k+1), no bytes are sent, state stays IDLE.
- Simultaneous START and SEND_RESET: SEND_RESET wins and START is dropped.
- START or SEND_RESET while BUSY: ignored, not queued.
- Input changes during a frame have no effect (snapshot only).
- RST mid-frame: next edge returns all outputs to reset values and the remaining bytes are abandoned. RST has priority over all requests.
- FLAG is never high for more than one consecutive cycle.

Optional Feature:
RECEP_ALARM_ONLY_EN:
- Defined: input ALARM_ONLY (1 bit) is sampled at START.
  - If ALARM_ONLY is high, the frame is H, then the P/A byte, then the optional G, then ENTER; temperature bytes are omitted and the TEMP checks are skipped.
  - If ALARM_ONLY is high with no alarm, the frame is H, ENTER.
- Not defined: the port is absent and every frame includes the temperatures.

Test Plan:
- GAP_CYCLES=2; START with TEMP1=25h, TEMP2=16h, PELIGRO=1, GAS=1 -> DATO 25,16,4D,34,5A with FLAG pulses 4 cycles apart, first FLAG at k+2, DONE at k+21, then DATO=5A.
- START with ALERTA=1, PELIGRO=0, GAS=0, TEMP1=30h, TEMP2=31h -> bytes 30,31,1C,5A; no G byte; BUSY high for exactly 4×(2+GAP) cycles.
- START with TEMP1=33h -> ERR pulse at k+1, FLAG stays 0, BUSY stays 0. Repeat with TEMP2=5Ah -> same response.
- START and SEND_RESET in the same cycle -> bytes 2D,00 only, DONE after 2 byte periods; a receiver model clears all flags and temps.
- RST asserted during the third byte's GAP -> next cycle DATO=5A, FLAG=0, BUSY=0, no DONE; START 2 cycles later produces a full, correct frame.
- START pulsed again while BUSY -> ignored; exactly one frame is emitted and one DONE.
